buffer_pingpong_ctrl: RTL and testbench

Sequencer for the ping-pong accumulating buffer array at the output of the stochastic-computing datapath. It drives bank select and clear, and gates upstream bitstreams into fixed-length accumulation windows. It swaps banks at each window boundary and presents each finished bank to a downstream reader through a valid/ready handshake, back-pressuring the datapath when the reader is slow.

---
 rtl/buffer_pingpong_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_buffer_pingpong_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_pingpong_ctrl.sv
// ============================================================================
// buffer_pingpong_ctrl
// ----------------------------------------------------------------------------
// Sequencer for the ping-pong accumulating buffer array at the output of the
// stochastic-computing datapath. It gates upstream bitstreams into windows of
// iLen cycles and clears the accumulating bank before each window. At each
// window boundary it swaps banks and presents the finished bank to a
// downstream reader through a valid/ready handshake.
//
// Optional feature macro: BUF_CTRL_BACKPRESSURE_EN
//   defined   : a WAIT state holds the datapath idle until the reader has
//               consumed the previous bank (iOutReady honoured).
//   undefined : every window end swaps unconditionally. oOutValid is a
//               one-cycle pulse and iOutReady is ignored.
//
// Parameters:
//   CWID      width of iLen (max window 2^CWID-1 cycles)
//   NWID      width of iNumWin and oWinCnt
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   iStart     start a run (sampled only when idle)
//   iLen       accumulation cycles per window (0 = start ignored)
//   iNumWin    windows per run, 0 = continuous until iStop
//   iStop      end the run after the current window
//   oAccSel    bank select: 0 = bank0 accumulates, bank1 readable
//   oClear     clear the accumulating bank this cycle
//   oAccEn     upstream drives valid bits when 1, zero bits when 0
//   oOutValid  readable bank holds a finished window
//   iOutReady  reader consumes the readable bank when oOutValid=1
//   oBusy      run in progress, until the last result is consumed
//   oDone      one-cycle pulse when a run completes
//   oWinCnt    windows completed in this run (wraps)
// ============================================================================
module buffer_pingpong_ctrl #(
    parameter int CWID = 8,
    parameter int NWID = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iStart,
    input  logic [CWID-1:0] iLen,
    input  logic [NWID-1:0] iNumWin,
    input  logic            iStop,
    output logic            oAccSel,
    output logic            oClear,
    output logic            oAccEn,
    output logic            oOutValid,
    input  logic            iOutReady,
    output logic            oBusy,
    output logic            oDone,
    output logic [NWID-1:0] oWinCnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACC,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t          r_state;
    logic            r_sel;
    logic            r_clear;
    logic            r_acc_en;
    logic            r_out_valid;
    logic            r_busy;
    logic            r_done;
    logic [NWID-1:0] r_wincnt;
    logic [CWID-1:0] r_cnt;
    logic [CWID-1:0] r_len;
    logic [NWID-1:0] r_numwin;
    logic            r_stop_pend;

    state_t          w_state_nxt;
    logic            w_sel_nxt;
    logic            w_clear_nxt;
    logic            w_acc_en_nxt;
    logic            w_out_valid_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic [NWID-1:0] w_wincnt_nxt;
    logic [CWID-1:0] w_cnt_nxt;
    logic [CWID-1:0] w_len_nxt;
    logic [NWID-1:0] w_numwin_nxt;
    logic            w_stop_nxt;

    logic            w_free;
    logic            w_swap;
    logic            w_finish;
    logic            w_stop_now;
    logic            w_last;
    logic [NWID-1:0] w_wincnt_inc;

`ifdef BUF_CTRL_BACKPRESSURE_EN
    logic            w_hs;

    assign w_hs   = r_out_valid && iOutReady;
    // The readable bank may be overwritten only once the reader is done with it,
    // which includes a handshake happening in this very cycle.
    assign w_free = !r_out_valid || w_hs;
`else
    logic            w_unused_ready;

    assign w_unused_ready = iOutReady;
    assign w_free         = 1'b1;
`endif

    assign w_stop_now   = r_stop_pend || iStop;
    assign w_wincnt_inc = r_wincnt + NWID'(1);
    // A stop raised in the final accumulation cycle still ends this window.
    assign w_last       = ((r_numwin != '0) && (w_wincnt_inc == r_numwin)) || w_stop_now;

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_clear_nxt     = 1'b0;
        w_acc_en_nxt    = 1'b0;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_wincnt_nxt    = r_wincnt;
        w_cnt_nxt       = r_cnt;
        w_len_nxt       = r_len;
        w_numwin_nxt    = r_numwin;
        w_stop_nxt      = r_stop_pend;
        w_swap          = 1'b0;
        w_finish        = 1'b0;
`ifdef BUF_CTRL_BACKPRESSURE_EN
        w_out_valid_nxt = r_out_valid && !w_hs;
`else
        w_out_valid_nxt = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                if (iStart && (iLen != '0)) begin
                    w_state_nxt  = S_CLEAR;
                    w_clear_nxt  = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_wincnt_nxt = '0;
                    w_len_nxt    = iLen;
                    w_numwin_nxt = iNumWin;
                    w_stop_nxt   = 1'b0;
                end
            end
            S_CLEAR: begin
                w_stop_nxt   = w_stop_now;
                w_state_nxt  = S_ACC;
                w_acc_en_nxt = 1'b1;
                w_cnt_nxt    = '0;
            end
            S_ACC: begin
                w_stop_nxt = w_stop_now;
                w_cnt_nxt  = r_cnt + CWID'(1);
                if (r_cnt == (r_len - CWID'(1))) begin
                    if (w_free) begin
                        w_swap = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end else begin
                    w_acc_en_nxt = 1'b1;
                end
            end
`ifdef BUF_CTRL_BACKPRESSURE_EN
            S_WAIT: begin
                w_stop_nxt = w_stop_now;
                if (w_free) begin
                    w_swap = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_hs) begin
                    w_finish = 1'b1;
                end
            end
`else
            S_DRAIN: begin
                w_finish = 1'b1;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Bank swap: the finished bank becomes readable and accumulation moves
        // to the other bank, or the run drains if this was its last window.
        if (w_swap) begin
            w_sel_nxt       = ~r_sel;
            w_out_valid_nxt = 1'b1;
            w_wincnt_nxt    = w_wincnt_inc;
            if (w_last) begin
                w_state_nxt = S_DRAIN;
            end else begin
                w_state_nxt = S_CLEAR;
                w_clear_nxt = 1'b1;
            end
        end

        if (w_finish) begin
            w_state_nxt     = S_IDLE;
            w_out_valid_nxt = 1'b0;
            w_busy_nxt      = 1'b0;
            w_done_nxt      = 1'b1;
            w_stop_nxt      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sel       <= 1'b0;
            r_clear     <= 1'b0;
            r_acc_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wincnt    <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_numwin    <= '0;
            r_stop_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_clear     <= w_clear_nxt;
            r_acc_en    <= w_acc_en_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_wincnt    <= w_wincnt_nxt;
            r_cnt       <= w_cnt_nxt;
            r_len       <= w_len_nxt;
            r_numwin    <= w_numwin_nxt;
            r_stop_pend <= w_stop_nxt;
        end
    end

    assign oAccSel   = r_sel;
    assign oClear    = r_clear;
    assign oAccEn    = r_acc_en;
    assign oOutValid = r_out_valid;
    assign oBusy     = r_busy;
    assign oDone     = r_done;
    assign oWinCnt   = r_wincnt;

endmodule

// File: tb/tb_buffer_pingpong_ctrl.sv
// ============================================================================
// tb_buffer_pingpong_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for buffer_pingpong_ctrl. A procedural reference model
// walks each run window by window (clear cycle, iLen accumulation cycles,
// stall until the reader frees the readable bank, swap, drain) while choosing
// random reader-ready, stop and stray-start stimulus, and compares every
// output of the design every cycle.
// ============================================================================
module tb_buffer_pingpong_ctrl;

    logic       clk;
    logic       rst;
    logic       iStart;
    logic [7:0] iLen;
    logic [7:0] iNumWin;
    logic       iStop;
    logic       oAccSel;
    logic       oClear;
    logic       oAccEn;
    logic       oOutValid;
    logic       iOutReady;
    logic       oBusy;
    logic       oDone;
    logic [7:0] oWinCnt;

    buffer_pingpong_ctrl #(
        .CWID(8),
        .NWID(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iStart    (iStart),
        .iLen      (iLen),
        .iNumWin   (iNumWin),
        .iStop     (iStop),
        .oAccSel   (oAccSel),
        .oClear    (oClear),
        .oAccEn    (oAccEn),
        .oOutValid (oOutValid),
        .iOutReady (iOutReady),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oWinCnt   (oWinCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // expected output state
    logic       e_sel, e_clear, e_accen, e_valid, e_busy, e_done;
    logic [7:0] e_wincnt;

    // stimulus plan for the current run
    int cyc_n;
    int stop_at;
    int rdy_pct;
    bit rdy_delay;
    int vld_at;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return {18'd0, oAccSel, oClear, oAccEn, oOutValid, oBusy, oDone, oWinCnt};
    endfunction

    function automatic logic [31:0] exp_outs();
        return {18'd0, e_sel, e_clear, e_accen, e_valid, e_busy, e_done, e_wincnt};
    endfunction

    // One clock cycle: choose inputs, compare outputs, advance past the edge.
    task automatic cyc(input string tag, input bit rnd_start, output bit hs, output bit stp);
        if (rdy_delay) begin
            if (e_valid && vld_at < 0) vld_at = cyc_n;
            iOutReady = (vld_at >= 0) && (cyc_n >= vld_at + 6);
        end else begin
            iOutReady = ($urandom_range(99) < rdy_pct);
        end
        stp   = (cyc_n == stop_at);
        iStop = stp;
        if (rnd_start) begin
            iStart  = ($urandom_range(3) == 0);
            iLen    = 8'($urandom);
            iNumWin = 8'($urandom);
        end
        chk(tag, dut_outs(), exp_outs());
`ifdef BUF_CTRL_BACKPRESSURE_EN
        hs = e_valid && iOutReady;
`else
        hs = 1'b0;
`endif
        @(posedge clk);
        #1;
        cyc_n++;
        e_done = 1'b0;
`ifdef BUF_CTRL_BACKPRESSURE_EN
        if (hs) e_valid = 1'b0;
`else
        e_valid = 1'b0;
`endif
    endtask

    // Complete run from the start cycle through the cycle after oDone.
    task automatic run(input int len, input logic [7:0] nwin, input int stop_cyc, input int pct);
        bit hs, stp, stop_pend, v_before, free;
        int guard;
        cyc_n   = 0;
        vld_at  = -1;
        stop_at = stop_cyc;
        rdy_pct = pct;
        iStart  = 1'b1;
        iLen    = 8'(len);
        iNumWin = nwin;
        cyc("start", 1'b0, hs, stp);
        iStart    = 1'b0;
        e_clear   = 1'b1;
        e_busy    = 1'b1;
        e_wincnt  = 8'd0;
        stop_pend = 1'b0;
        forever begin
            cyc("clear", 1'b1, hs, stp);
            stop_pend |= stp;
            e_clear = 1'b0;
            e_accen = 1'b1;
            for (int k = 0; k < len - 1; k++) begin
                cyc("acc", 1'b1, hs, stp);
                stop_pend |= stp;
            end
            v_before = e_valid;
            cyc("acc_end", 1'b1, hs, stp);
            stop_pend |= stp;
            e_accen = 1'b0;
`ifdef BUF_CTRL_BACKPRESSURE_EN
            free = !v_before || hs;
`else
            free = 1'b1;
`endif
            guard = 0;
            while (!free) begin
                cyc("wait", 1'b1, hs, stp);
                stop_pend |= stp;
                free = hs;
                guard++;
                if (guard > 2000) begin
                    chk("wait_bound", 32'(guard), 32'd0);
                    free = 1'b1;
                end
            end
            e_sel    = ~e_sel;
            e_valid  = 1'b1;
            e_wincnt = e_wincnt + 8'd1;
            if ((nwin != 8'd0 && e_wincnt == nwin) || stop_pend) break;
            e_clear = 1'b1;
        end
`ifdef BUF_CTRL_BACKPRESSURE_EN
        hs    = 1'b0;
        guard = 0;
        while (!hs) begin
            cyc("drain", 1'b1, hs, stp);
            guard++;
            if (guard > 2000) begin
                chk("drain_bound", 32'(guard), 32'd0);
                hs = 1'b1;
            end
        end
`else
        cyc("drain", 1'b1, hs, stp);
`endif
        e_busy  = 1'b0;
        e_done  = 1'b1;
        e_valid = 1'b0;
        iStart  = 1'b0;
        cyc("done", 1'b0, hs, stp);
        iStop = 1'b0;
    endtask

    initial begin
        bit hs, stp;
        int len, pct, sc;
        logic [7:0] nw;
        rst       = 1'b1;
        iStart    = 1'b0;
        iLen      = 8'd0;
        iNumWin   = 8'd0;
        iStop     = 1'b0;
        iOutReady = 1'b0;
        e_sel = 0; e_clear = 0; e_accen = 0; e_valid = 0; e_busy = 0; e_done = 0;
        e_wincnt  = 8'd0;
        cyc_n = 0; stop_at = -1; rdy_pct = 100; rdy_delay = 1'b0; vld_at = -1;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", dut_outs(), exp_outs());
        rst = 1'b0;
        @(posedge clk);
        #1;

        // reset asserted during the third accumulation cycle of a window
        iStart  = 1'b1;
        iLen    = 8'd8;
        iNumWin = 8'd2;
        @(posedge clk);
        #1;
        iStart = 1'b0;
        chk("mid_clear", 32'(oClear), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_acc_en", 32'(oAccEn), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", dut_outs(), exp_outs());
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("after_reset", dut_outs(), exp_outs());

        // start with zero length is ignored
        iStart = 1'b1;
        iLen   = 8'd0;
        cyc("len0_a", 1'b0, hs, stp);
        iStart = 1'b0;
        cyc("len0_b", 1'b0, hs, stp);
        chk("len0_busy", 32'(oBusy), 32'd0);

        // basic run
        run(4, 8'd3, -1, 100);
        chk("basic_wincnt", 32'(oWinCnt), 32'd3);

        // reader holds off until six cycles after the first valid
        rdy_delay = 1'b1;
        run(2, 8'd2, -1, 0);
        rdy_delay = 1'b0;
        chk("bp_wincnt", 32'(oWinCnt), 32'd2);

        // continuous run stopped in the middle of window 5
        run(3, 8'd0, 19, 100);
        chk("stop_wincnt", 32'(oWinCnt), 32'd5);

        // continuous run long enough for the window counter to wrap (258 windows)
        run(1, 8'd0, 516, 100);
        chk("wrap_wincnt", 32'(oWinCnt), 32'd2);

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(1, 6);
            nw  = 8'($urandom_range(0, 5));
            pct = $urandom_range(20, 100);
            if (nw == 8'd0 || $urandom_range(1) == 1) sc = $urandom_range(1, 40);
            else sc = -1;
            run(len, nw, sc, pct);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
